// File: rtl/ext_mem_arbiter_pkg.sv
// Shared definitions for the external memory bus controller: FSM encodings,
// command-word field positions and requester port indices.
package ext_mem_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CMD   = 3'd1;
    localparam state_t ST_WDATA = 3'd2;
    localparam state_t ST_TURN  = 3'd3;
    localparam state_t ST_RDATA = 3'd4;
    localparam state_t ST_GAP   = 3'd5;

    localparam int WRITE_BIT = 31;
    localparam int LEN_LSB   = 27;
    localparam int ADDR_LSB  = 0;

    localparam int IFETCH = 0;
    localparam int LSU    = 1;

endpackage

// File: rtl/ext_mem_rr_arb.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// port that was not granted last.
module ext_mem_rr_arb (
    input  logic [1:0] valid_i,
    input  logic       rr_last_i,
    output logic       grant_o,
    output logic       gnt_valid_o
);

    always_comb begin
        gnt_valid_o = |valid_i;
        case (valid_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~rr_last_i;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Shares the multiplexed 32-bit external memory bus between instruction fetch
// and load/store: arbitrates, then runs command, turnaround and burst phases.
//
// state    | meaning
// IDLE     | waiting for a request, grant is combinational
// CMD      | drive command word {write, len, addr}
// WDATA    | drive len+1 write words from the granted port
// TURN     | bus released for one cycle before read data
// RDATA    | sample len+1 read words from bus_i
// GAP      | bus idle, done pulse to the granted port
module ext_mem_arbiter
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W = 27,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*LEN_W-1:0]    req_len,
    input  logic [63:0]           wdata,
    output logic [1:0]            wdata_ready,
    output logic [31:0]           rdata,
    output logic [1:0]            rdata_valid,
    output logic [1:0]            done,
    output logic                  mem_en,
    output logic [31:0]           bus_o,
    output logic                  bus_oe,
    input  logic [31:0]           bus_i
);

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                rr_last_q, rr_last_d;
    logic [31:0]         rdata_q;
    logic [1:0]          rdata_valid_q;

    logic                arb_gnt;
    logic                arb_vld;
    logic                accept;
    logic [1:0]          gnt_onehot;
    logic [31:0]         cmd_word;
    logic [31:0]         wdata_sel;

    ext_mem_rr_arb u_arb (
        .valid_i     (req_valid),
        .rr_last_i   (rr_last_q),
        .grant_o     (arb_gnt),
        .gnt_valid_o (arb_vld)
    );

    assign accept     = (state_q == ST_IDLE) && arb_vld;
    assign gnt_onehot = {gnt_q, ~gnt_q};
    assign wdata_sel  = gnt_q ? wdata[LSU*32 +: 32] : wdata[IFETCH*32 +: 32];

    always_comb begin
        cmd_word                       = '0;
        cmd_word[WRITE_BIT]            = write_q;
        cmd_word[LEN_LSB +: LEN_W]     = len_q;
        cmd_word[ADDR_LSB +: ADDR_W]   = addr_q;
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_CMD;
                    gnt_d     = arb_gnt;
                    write_d   = req_write[arb_gnt];
                    addr_d    = arb_gnt ? req_addr[LSU*ADDR_W +: ADDR_W]
                                        : req_addr[IFETCH*ADDR_W +: ADDR_W];
                    len_d     = arb_gnt ? req_len[LSU*LEN_W +: LEN_W]
                                        : req_len[IFETCH*LEN_W +: LEN_W];
                    rr_last_d = arb_gnt;
                    cnt_d     = '0;
                end
            end
            ST_CMD:  state_d = write_q ? ST_WDATA : ST_TURN;
            ST_TURN: state_d = ST_RDATA;
            ST_WDATA, ST_RDATA: begin
                // Compare against the latched length so a full 2**LEN_W burst never wraps early
                if (cnt_q == len_q) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            gnt_q         <= 1'b0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            rr_last_q     <= 1'b1;
            rdata_q       <= '0;
            rdata_valid_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            rr_last_q     <= rr_last_d;
            rdata_valid_q <= (state_q == ST_RDATA) ? gnt_onehot : 2'b00;
            if (state_q == ST_RDATA) begin
                rdata_q <= bus_i;
            end
        end
    end

    always_comb begin
        req_ready   = accept ? {arb_gnt, ~arb_gnt} : 2'b00;
        mem_en      = (state_q == ST_CMD) || (state_q == ST_WDATA) ||
                      (state_q == ST_TURN) || (state_q == ST_RDATA);
        bus_oe      = (state_q == ST_CMD) || (state_q == ST_WDATA);
        bus_o       = (state_q == ST_CMD)   ? cmd_word  :
                      (state_q == ST_WDATA) ? wdata_sel : 32'h0;
        wdata_ready = (state_q == ST_WDATA) ? gnt_onehot : 2'b00;
        done        = (state_q == ST_GAP)   ? gnt_onehot : 2'b00;
        rdata       = rdata_q;
        rdata_valid = rdata_valid_q;
    end

endmodule
